// File: rtl/ofm_writer.sv
// ofm_writer: requantizes a signed accumulator stream and writes one frame to OFM SRAM; define OFM_ROUND_EN for round-half-up before the shift
module ofm_writer #(
  parameter int ACC_WIDTH    = 20,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_BITS    = 11,
  parameter int FRAME_PIXELS = 784,
  parameter int SHIFT        = 8
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic                  in_valid,
  input  logic [ACC_WIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  sram_write_en,
  output logic [ADDR_BITS-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_BITS:0]    pix_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [ADDR_BITS:0] FRAME = FRAME_PIXELS[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] ONE = 1;
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  state_t state, state_nxt;
  logic [ADDR_BITS-1:0] base;
  logic accept;
  logic signed [ACC_WIDTH:0] s;
  logic [DATA_WIDTH-1:0] q;
`ifdef OFM_ROUND_EN
  localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
  assign s = ($signed({in_data[ACC_WIDTH-1], in_data}) + $signed(HALF)) >>> SHIFT;
`else
  assign s = $signed({in_data[ACC_WIDTH-1], in_data}) >>> SHIFT;
`endif
  assign q = s[ACC_WIDTH] ? '0 : (s > MAXV) ? '1 : s[DATA_WIDTH-1:0];
  assign accept = in_valid && in_ready;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state and state-decoded outputs; ready only while the frame still needs pixels
  always_comb begin
    state_nxt = state;
    in_ready = 1'b0;
    busy = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        in_ready = pix_count < FRAME;
        if (in_valid && in_ready && pix_count == FRAME - ONE) state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        frame_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // frame base/count capture and registered SRAM write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      pix_count <= '0;
      sram_write_en <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
    end else begin
      sram_write_en <= accept;
      if (state == IDLE && start) begin
        base <= base_addr;
        pix_count <= '0;
      end
      if (accept) begin
        sram_addr <= base + pix_count[ADDR_BITS-1:0];
        sram_wdata <= q;
        pix_count <= pix_count + ONE;
      end
    end
endmodule
